// File: rtl/rx_pid_capture.sv
// rx_pid_capture: USB receive framer - SYNC hunt, PID capture, payload byte framing, EOP detect.
// Ports: clk, rst (async, active-low); bit_in/bit_valid/se0 decoded bit stream with SE0 detect;
//        PID_I/PID_enable captured PID and its valid level; data_byte/byte_ready payload bytes;
//        EOP_flag end-of-packet pulse; rx_error framing/overflow/PID error pulse.
// Define PID_CHECK_EN to reject PIDs whose upper nibble is not the complement of the lower.
module rx_pid_capture #(
    parameter int MAX_BYTES    = 1027,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       se0,
    output logic [7:0] PID_I,
    output logic       PID_enable,
    output logic [7:0] data_byte,
    output logic       byte_ready,
    output logic       EOP_flag,
    output logic       rx_error
);
    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam int SW = $clog2(EOP_SE0_BITS + 1);
    typedef enum logic [1:0] {IDLE, PID, DATA, EOP_WAIT} state_t;
    state_t        state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] byte_cnt;
    logic [SW-1:0] se0_cnt;
    logic [7:0]    shift_nx;
    logic          eop_hit;
    logic          pid_ok;
    assign shift_nx = {bit_in, shift_reg[7:1]};
    assign eop_hit  = se0 && se0_cnt == SW'(EOP_SE0_BITS - 1);
`ifdef PID_CHECK_EN
    assign pid_ok = shift_nx[7:4] == ~shift_nx[3:0];
`else
    assign pid_ok = 1'b1;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_cnt   <= '0;
            se0_cnt    <= '0;
            PID_I      <= 8'h00;
            PID_enable <= 1'b0;
            data_byte  <= 8'h00;
            byte_ready <= 1'b0;
            EOP_flag   <= 1'b0;
            rx_error   <= 1'b0;
        end else begin
            byte_ready <= 1'b0;
            EOP_flag   <= 1'b0;
            rx_error   <= 1'b0;
            // PID_enable is held through the EOP pulse and dropped one cycle later
            if (EOP_flag) PID_enable <= 1'b0;
            if (bit_valid) begin
                if (state == IDLE) begin
                    shift_reg <= se0 ? 8'h00 : shift_nx;
                    if (!se0 && shift_nx == 8'h80) begin
                        state   <= PID;
                        bit_cnt <= 3'd0;
                    end
                end else if (se0) begin
                    se0_cnt <= se0_cnt + 1'b1;
                    if (eop_hit) begin
                        state     <= IDLE;
                        shift_reg <= 8'h00;
                        bit_cnt   <= 3'd0;
                        byte_cnt  <= '0;
                        se0_cnt   <= '0;
                        EOP_flag  <= state != PID;
                        rx_error  <= state == PID || (state == DATA && bit_cnt != 3'd0);
                    end
                end else begin
                    se0_cnt <= '0;
                    if (state != EOP_WAIT) begin
                        shift_reg <= shift_nx;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == PID) begin
                                PID_I      <= shift_nx;
                                PID_enable <= pid_ok;
                                rx_error   <= !pid_ok;
                                state      <= pid_ok ? DATA : EOP_WAIT;
                            end else if (byte_cnt == BW'(MAX_BYTES)) begin
                                rx_error <= 1'b1;
                                state    <= EOP_WAIT;
                            end else begin
                                data_byte  <= shift_nx;
                                byte_ready <= 1'b1;
                                byte_cnt   <= byte_cnt + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_pid_capture.sv
// tb_rx_pid_capture: randomized packet-level bench for rx_pid_capture with directed literal cases.
module tb_rx_pid_capture;
    localparam int MB = 2;
    logic       clk = 1'b0;
    logic       rst, bit_in, bit_valid, se0;
    logic [7:0] PID_I, data_byte;
    logic       PID_enable, byte_ready, EOP_flag, rx_error;
    logic [7:0] e_pid, e_data;
    logic       e_pen, e_ready, e_eop, e_err, drop;
    logic [7:0] dat [4];
    logic [7:0] rd [$];
    int n_chk = 0, n_fail = 0;
    int n_ready, n_eop, n_err, n_both, n_pen;
    rx_pid_capture #(.MAX_BYTES(MB), .EOP_SE0_BITS(2)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .se0(se0),
        .PID_I(PID_I), .PID_enable(PID_enable), .data_byte(data_byte),
        .byte_ready(byte_ready), .EOP_flag(EOP_flag), .rx_error(rx_error)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        chk("PID_I", PID_I, e_pid);
        chk("PID_enable", {7'd0, PID_enable}, {7'd0, e_pen});
        chk("data_byte", data_byte, e_data);
        chk("byte_ready", {7'd0, byte_ready}, {7'd0, e_ready});
        chk("EOP_flag", {7'd0, EOP_flag}, {7'd0, e_eop});
        chk("rx_error", {7'd0, rx_error}, {7'd0, e_err});
        if (byte_ready) begin n_ready++; rd.push_back(data_byte); end
        if (EOP_flag) n_eop++;
        if (rx_error) n_err++;
        if (EOP_flag && rx_error) n_both++;
        if (PID_enable) n_pen++;
    end
    task automatic clr();
        n_ready = 0; n_eop = 0; n_err = 0; n_both = 0; n_pen = 0;
        rd.delete();
    endtask
    task automatic model_reset();
        e_pid = 8'h00; e_data = 8'h00; e_pen = 1'b0;
        e_ready = 1'b0; e_eop = 1'b0; e_err = 1'b0; drop = 1'b0;
    endtask
    // One clock: drive on the falling edge, then set the post-edge expectation defaults.
    task automatic tick(input logic bv, input logic b, input logic s);
        @(negedge clk);
        bit_valid = bv; bit_in = b; se0 = s;
        @(posedge clk);
        e_ready = 1'b0; e_eop = 1'b0; e_err = 1'b0;
        if (drop) begin e_pen = 1'b0; drop = 1'b0; end
    endtask
    task automatic gap();
        repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom), 1'($urandom));
    endtask
    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask
    task automatic glitch();
        if ($urandom_range(0, 7) == 0) begin tick(1'b1, 1'($urandom), 1'b1); gap(); end
    endtask
    // Sends one whole packet and states, strobe by strobe, what the outputs must become.
    task automatic packet(input logic [7:0] pid, input int pbits, input int nb, input int part);
        bit dead;
        int cnt;
        logic [7:0] d;
        dead = 1'b0;
        cnt  = 0;
        repeat ($urandom_range(0, 2)) begin tick(1'b1, 1'($urandom), 1'b1); gap(); end
        for (int i = 0; i < 8; i++) begin tick(1'b1, i == 7, 1'b0); gap(); end
        for (int i = 0; i < pbits; i++) begin
            glitch();
            tick(1'b1, pid[i], 1'b0);
            if (i == 7) begin
                e_pid = pid;
`ifdef PID_CHECK_EN
                dead = pid[7:4] != ~pid[3:0];
`endif
                e_pen = !dead;
                e_err = dead;
            end
            gap();
        end
        if (pbits == 8) begin
            for (int j = 0; j < nb; j++) begin
                d = dat[j];
                for (int i = 0; i < 8; i++) begin
                    glitch();
                    tick(1'b1, d[i], 1'b0);
                    if (i == 7 && !dead) begin
                        if (cnt < MB) begin
                            e_ready = 1'b1; e_data = d; cnt++;
                        end else begin
                            e_err = 1'b1; dead = 1'b1;
                        end
                    end
                    gap();
                end
            end
            for (int i = 0; i < part; i++) begin glitch(); tick(1'b1, 1'($urandom), 1'b0); gap(); end
        end
        tick(1'b1, 1'($urandom), 1'b1);
        gap();
        tick(1'b1, 1'($urandom), 1'b1);
        if (pbits < 8) e_err = 1'b1;
        else begin
            e_eop = 1'b1;
            e_err = !dead && part != 0;
            drop  = 1'b1;
        end
        gap();
    endtask
    initial begin
        rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; se0 = 1'b0;
        model_reset();
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pid", PID_I, 8'h00);
        chk("rst_pen", {7'd0, PID_enable}, 8'h00);
        chk("rst_eop", {7'd0, EOP_flag}, 8'h00);
        #1 rst = 1'b1;
        clr();
        packet(8'hC3, 8, 0, 0);
        idle(2);
        chk("t2_pid", PID_I, 8'hC3);
        chk("t2_eop_cnt", 8'(n_eop), 8'd1);
        chk("t2_err_cnt", 8'(n_err), 8'd0);
        chk("t2_pen_seen", {7'd0, n_pen != 0}, 8'd1);
        clr();
        dat[0] = 8'hA5; dat[1] = 8'h5A;
        packet(8'hC3, 8, 2, 0);
        idle(2);
        chk("t3_ready_cnt", 8'(n_ready), 8'd2);
        chk("t3_byte0", rd[0], 8'hA5);
        chk("t3_byte1", rd[1], 8'h5A);
        chk("t3_eop_cnt", 8'(n_eop), 8'd1);
        chk("t3_err_cnt", 8'(n_err), 8'd0);
        clr();
        packet(8'h3C, 8, 0, 3);
        idle(2);
        chk("t4_both", 8'(n_both), 8'd1);
        chk("t4_err_cnt", 8'(n_err), 8'd1);
        chk("t4_ready_cnt", 8'(n_ready), 8'd0);
        clr();
        packet(8'hC4, 8, 0, 0);
        idle(2);
`ifdef PID_CHECK_EN
        chk("t5_err_cnt", 8'(n_err), 8'd1);
        chk("t5_pen_seen", 8'(n_pen), 8'd0);
`else
        chk("t5_pid", PID_I, 8'hC4);
        chk("t5_err_cnt", 8'(n_err), 8'd0);
`endif
        chk("t5_eop_cnt", 8'(n_eop), 8'd1);
        clr();
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        packet(8'hC3, 8, 3, 0);
        idle(2);
        chk("t6_ready_cnt", 8'(n_ready), 8'd2);
        chk("t6_last_byte", data_byte, 8'h22);
        chk("t6_err_cnt", 8'(n_err), 8'd1);
        chk("t6_eop_cnt", 8'(n_eop), 8'd1);
        clr();
        packet(8'hC3, 5, 0, 0);
        idle(2);
        chk("pidcut_err_cnt", 8'(n_err), 8'd1);
        chk("pidcut_eop_cnt", 8'(n_eop), 8'd0);
        chk("pidcut_pen", 8'(n_pen), 8'd0);
        clr();
        for (int i = 0; i < 8; i++) tick(1'b1, i == 7, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, (8'hC3 >> i) & 8'h01, 1'b0);
            if (i == 7) begin e_pid = 8'hC3; e_pen = 1'b1; end
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0; bit_valid = 1'b0;
        model_reset();
        #1;
        chk("t1_pid", PID_I, 8'h00);
        chk("t1_pen", {7'd0, PID_enable}, 8'h00);
        chk("t1_data", data_byte, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        chk("t1_eop_cnt", 8'(n_eop), 8'd0);
        chk("t1_ready_cnt", 8'(n_ready), 8'd0);
        for (int k = 0; k < 120; k++) begin
            for (int j = 0; j < 4; j++) dat[j] = 8'($urandom);
            packet(8'($urandom), ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : 8,
                   $urandom_range(0, 3), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7));
            idle($urandom_range(0, 3));
        end
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
